// File: rtl/cache_loader_if.sv
// Bundles the loader's byte-stream sink and its memory data-port master.
// The master view belongs to cache_loader; the slave view belongs to
// whatever supplies bytes and owns the memory.
interface cache_loader_if;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        we;
  logic [31:0] d_addr;
  logic [31:0] di;
  logic [31:0] rdo;

  modport master (
    input  s_valid, s_data, rdo,
    output s_ready, we, d_addr, di
  );

  modport slave (
    output s_valid, s_data, rdo,
    input  s_ready, we, d_addr, di
  );
endinterface

// File: rtl/cache_loader.sv
// Boot-time memory loader: receives a length-prefixed byte stream, packs
// it into little-endian words, writes them from BASE upward, then reads
// everything back and compares XOR checksums. The CPU is held off the
// memory for the whole load.
module cache_loader #(
  parameter int BASE  = 0,
  parameter int DEPTH = 512
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  cache_loader_if.master     bus,
  output logic               o_cpu_hold,
  output logic               o_done,
  output logic               o_err,
  output logic [15:0]        o_words
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_VERIFY, S_DONE, S_ERR
  } state_t;

  localparam logic [31:0] BASE_ADDR = 32'(BASE);
  localparam logic [31:0] ROOM      = 32'(DEPTH - BASE);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_len;
  logic [1:0]  r_lane;
  logic [31:0] r_word;
  logic [31:0] r_csum;
  logic [31:0] r_rsum;
  logic [15:0] r_k;
  logic [15:0] r_words;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_di;

  logic        w_s_ready;
  logic        w_xfer;
  logic [15:0] w_len_full;
  logic [16:0] w_words_inc;
  logic [31:0] w_rsum_next;
  logic        w_idle_like;

  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR);
  assign w_s_ready   = (r_state == S_LEN0) || (r_state == S_LEN1) || (r_state == S_DATA);
  assign w_xfer      = bus.s_valid & w_s_ready;
  assign w_len_full  = {bus.s_data, r_len[7:0]};
  assign w_words_inc = {1'b0, r_words} + 17'd1;
  assign w_rsum_next = r_rsum ^ bus.rdo;

  assign bus.s_ready = w_s_ready;
  assign bus.we      = r_we;
  assign bus.d_addr  = r_addr;
  assign bus.di      = r_di;
  assign o_cpu_hold  = !w_idle_like;
  assign o_done      = (r_state == S_DONE);
  assign o_err       = (r_state == S_ERR);
  assign o_words     = r_words;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decision: length parsing, per-word write, then readback compare.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (i_start) w_next = S_LEN0;
      S_LEN0: if (w_xfer) w_next = S_LEN1;
      S_LEN1: begin
        if (w_xfer) begin
          if (w_len_full == 16'd0)             w_next = S_DONE;
          else if ({16'd0, w_len_full} > ROOM) w_next = S_ERR;
          else                                 w_next = S_DATA;
        end
      end
      S_DATA: if (w_xfer && (r_lane == 2'd3)) w_next = S_WRITE;
      S_WRITE: begin
        if (w_words_inc < {1'b0, r_len}) w_next = S_DATA;
        else                             w_next = S_VERIFY;
      end
      S_VERIFY: begin
        if (r_k == (r_len - 16'd1))
          w_next = (w_rsum_next == r_csum) ? S_DONE : S_ERR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: byte packing, registered memory port, checksums and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len   <= '0;
      r_lane  <= '0;
      r_word  <= '0;
      r_csum  <= '0;
      r_rsum  <= '0;
      r_k     <= '0;
      r_words <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_di    <= '0;
    end else begin
      r_we <= (w_next == S_WRITE);
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (i_start) begin
            r_words <= '0;
            r_lane  <= '0;
            r_csum  <= '0;
            r_rsum  <= '0;
            r_k     <= '0;
          end
        end
        S_LEN0: if (w_xfer) r_len[7:0] <= bus.s_data;
        S_LEN1: if (w_xfer) r_len[15:8] <= bus.s_data;
        S_DATA: begin
          if (w_xfer) begin
            r_word[{r_lane, 3'b000} +: 8] <= bus.s_data;
            r_lane <= r_lane + 2'd1;
            if (r_lane == 2'd3) begin
              r_addr <= BASE_ADDR + {16'd0, r_words};
              r_di   <= {bus.s_data, r_word[23:0]};
            end
          end
        end
        S_WRITE: begin
          r_csum  <= r_csum ^ r_word;
          r_words <= r_words + 16'd1;
          if (w_next == S_VERIFY) begin
            r_addr <= BASE_ADDR;
            r_k    <= '0;
            r_rsum <= '0;
          end
        end
        S_VERIFY: begin
          r_rsum <= w_rsum_next;
          r_k    <= r_k + 16'd1;
          if (w_next == S_VERIFY)
            r_addr <= BASE_ADDR + {16'd0, r_k} + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_loader.sv
// Self-checking bench for cache_loader: directed scenarios plus randomized
// loads, with a scoreboard fed from a length/word-level reference model.
module tb_cache_loader;

  localparam int BASE  = 0;
  localparam int DEPTH = 512;

  typedef struct {
    bit          isWrite;
    logic [31:0] addr;
    logic [31:0] data;
    bit          isErr;
    logic [15:0] words;
  } exp_t;

  logic clk;
  logic rst_n;
  logic i_start;
  logic o_cpu_hold, o_done, o_err;
  logic [15:0] o_words;

  cache_loader_if bus();

  cache_loader #(.BASE(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .bus(bus),
    .o_cpu_hold(o_cpu_hold), .o_done(o_done), .o_err(o_err), .o_words(o_words)
  );

  logic [31:0] mem [0:DEPTH-1];
  bit          corruptEn;
  int          writeCount;
  exp_t        sbq[$];
  int          total;
  int          bad;
  bit          prevDone, prevErr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.rdo = mem[bus.d_addr[8:0]] ^ {31'd0, (corruptEn && (bus.d_addr == 32'(BASE + 1)))};

  always @(posedge clk) begin
    if (bus.we) begin
      mem[bus.d_addr[8:0]] <= bus.di;
      writeCount <= writeCount + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per observed write or completion.
  always @(negedge clk) begin
    exp_t it;
    if (!rst_n) begin
      prevDone = 1'b0;
      prevErr  = 1'b0;
    end else begin
      if (bus.we) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL unexpected_write actual=%h required=none", bus.d_addr);
        end else begin
          it = sbq.pop_front();
          checkOutput("write_kind", 32'(1), 32'(it.isWrite));
          checkOutput("write_addr", bus.d_addr, it.addr);
          checkOutput("write_data", bus.di, it.data);
        end
      end
      if ((o_done && !prevDone) || (o_err && !prevErr)) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL unexpected_end actual=%0d%0d required=none", o_done, o_err);
        end else begin
          it = sbq.pop_front();
          checkOutput("end_kind", 32'(0), 32'(it.isWrite));
          checkOutput("end_done", 32'(o_done), 32'(!it.isErr));
          checkOutput("end_err", 32'(o_err), 32'(it.isErr));
          checkOutput("end_words", 32'(o_words), 32'(it.words));
        end
      end
      prevDone = o_done;
      prevErr  = o_err;
    end
  end

  // Reference model: length prefix, little-endian word packing, checksum outcome.
  task automatic pushExpected(input logic [7:0] bytes[$], input bit corrupt, output int expCycles);
    int n;
    exp_t it;
    n = {bytes[1], bytes[0]};
    if (n == 0) begin
      it = '{isWrite: 0, addr: 0, data: 0, isErr: 0, words: 16'd0};
      sbq.push_back(it);
      expCycles = 2;
    end else if (n > DEPTH - BASE) begin
      it = '{isWrite: 0, addr: 0, data: 0, isErr: 1, words: 16'd0};
      sbq.push_back(it);
      expCycles = 2;
    end else begin
      for (int i = 0; i < n; i++) begin
        it.isWrite = 1;
        it.addr    = 32'(BASE + i);
        it.data    = {bytes[2+4*i+3], bytes[2+4*i+2], bytes[2+4*i+1], bytes[2+4*i]};
        it.isErr   = 0;
        it.words   = 0;
        sbq.push_back(it);
      end
      it = '{isWrite: 0, addr: 0, data: 0, isErr: (corrupt && n >= 2), words: 16'(n)};
      sbq.push_back(it);
      expCycles = 2 + 6 * n;
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_s_ready"}, 32'(bus.s_ready), 32'd0);
    checkOutput({tag, "_we"}, 32'(bus.we), 32'd0);
    checkOutput({tag, "_d_addr"}, bus.d_addr, 32'd0);
    checkOutput({tag, "_di"}, bus.di, 32'd0);
    checkOutput({tag, "_cpu_hold"}, 32'(o_cpu_hold), 32'd0);
    checkOutput({tag, "_done"}, 32'(o_done), 32'd0);
    checkOutput({tag, "_err"}, 32'(o_err), 32'd0);
    checkOutput({tag, "_words"}, 32'(o_words), 32'd0);
  endtask

  // Runs one load: start pulse, byte feed with optional stalls, wait for completion.
  task automatic applyStimulus(input logic [7:0] bytes[$], input int stallAt, input int stallLen,
                               input bit randValid, input bit checkTime, input int resetAtWrite,
                               input bit midStart, input bit corrupt);
    int expCycles, cyc, idx, stallCnt, wBase;
    bit sr;
    corruptEn = corrupt;
    pushExpected(bytes, corrupt, expCycles);
    wBase = writeCount;
    @(negedge clk);
    i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    cyc = 0; idx = 0; stallCnt = 0;
    while (!(o_done || o_err) && cyc < 2000) begin
      @(negedge clk);
      i_start = (midStart && cyc == 3);
      if (idx < bytes.size() && !(idx == stallAt && stallCnt < stallLen)
          && !(randValid && $urandom_range(0, 3) == 0)) begin
        bus.s_valid = 1'b1;
        bus.s_data  = bytes[idx];
      end else begin
        bus.s_valid = 1'b0;
        bus.s_data  = 8'($urandom);
      end
      #1 sr = bus.s_ready;
      if (idx == stallAt && stallCnt < stallLen) begin
        stallCnt++;
        checkOutput("stall_s_ready", 32'(sr), 32'd1);
        checkOutput("stall_we", 32'(bus.we), 32'd0);
      end
      @(posedge clk);
      if (bus.s_valid && sr) idx++;
      cyc++;
      #1;
      i_start = 1'b0;
      if (resetAtWrite >= 0 && bus.we && (writeCount - wBase) == resetAtWrite) begin
        rst_n = 1'b0;
        #1;
        sbq.delete();
        checkReset("midreset");
        bus.s_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    bus.s_valid = 1'b0;
    if (!(o_done || o_err)) checkOutput("timeout", 32'(cyc), 32'd0);
    if (checkTime) checkOutput("latency", 32'(cyc), 32'(expCycles));
    checkOutput("cpu_hold_after", 32'(o_cpu_hold), 32'd0);
    @(negedge clk);
    #1 checkOutput("sb_drained", 32'(sbq.size()), 32'd0);
    sbq.delete();
    corruptEn = 1'b0;
  endtask

  initial begin
    logic [7:0] q[$];
    int n;
    total = 0; bad = 0; writeCount = 0; corruptEn = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'd0;
    i_start = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = 8'd0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkReset("reset");
    rst_n = 1'b1;

    $display("[TB] basic two-word load");
    q = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    applyStimulus(q, -1, 0, 0, 1, -1, 0, 0);
    checkOutput("mem0", mem[BASE], 32'h12345678);
    checkOutput("mem1", mem[BASE+1], 32'hDEADBEEF);

    $display("[TB] stalled stream");
    mem[BASE] = 32'd0; mem[BASE+1] = 32'd0;
    applyStimulus(q, 4, 7, 0, 0, -1, 0, 0);
    checkOutput("stall_mem0", mem[BASE], 32'h12345678);
    checkOutput("stall_mem1", mem[BASE+1], 32'hDEADBEEF);

    $display("[TB] oversize length");
    q = '{8'h01, 8'h02, 8'hAA};
    applyStimulus(q, -1, 0, 0, 1, -1, 0, 0);
    checkOutput("oversize_s_ready", 32'(bus.s_ready), 32'd0);
    checkOutput("oversize_err", 32'(o_err), 32'd1);

    $display("[TB] zero length");
    q = '{8'h00, 8'h00};
    applyStimulus(q, -1, 0, 0, 1, -1, 0, 0);
    checkOutput("zero_words", 32'(o_words), 32'd0);

    $display("[TB] corrupted readback");
    q = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    applyStimulus(q, -1, 0, 0, 1, -1, 0, 1);
    checkOutput("corrupt_done", 32'(o_done), 32'd0);

    $display("[TB] reset during third write");
    q = '{8'h05, 8'h00};
    for (int i = 0; i < 20; i++) q.push_back(8'($urandom));
    applyStimulus(q, -1, 0, 0, 0, 2, 0, 0);
    q = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    applyStimulus(q, -1, 0, 0, 1, -1, 0, 0);
    checkOutput("after_reset_mem0", mem[BASE], 32'h44332211);

    $display("[TB] randomized loads");
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 8);
      q = '{8'(n), 8'h00};
      for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
      applyStimulus(q, -1, 0, 1, 0, -1, 1, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_loader.md
# cache_loader

Boot-time initiator for the unified instruction/data memory's data port. Accepts a length-prefixed byte stream (from the debug UART receiver), packs bytes into little-endian 32-bit words, and writes them to consecutive word addresses. It then reads every word back through the same port and checks an XOR checksum. The CPU is held off the memory (`cpu_hold`) for the whole load.

## Interface
- `BASE`, 0: first word address written.
- `DEPTH`, 512: memory size in words; a load must fit in `[BASE, DEPTH)`.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle arm pulse; ignored unless in IDLE, DONE or ERR.
- `s_valid`  in  1  byte-stream valid.
- `s_data`  in  8  byte-stream data.
- `s_ready`  out  1  loader accepts a byte this cycle (transfer = `s_valid & s_ready`).
- `we`  out  1  memory write enable.
- `d_addr`  out  32  memory word address.
- `di`  out  32  memory write data.
- `do`  in  32  memory read data, combinational from `d_addr`, same cycle.
- `cpu_hold`  out  1  high in every state except IDLE, DONE and ERR.
- `done`  out  1  load and verify passed; held until next `start`.
- `err`  out  1  load rejected or verify failed; held until next `start`.
- `words`  out  16  words written in the current/last load.

## Operation
- States: IDLE, LEN0, LEN1, DATA, WRITE, VERIFY, DONE, ERR.
- IDLE/DONE/ERR + `start` -> LEN0. The transition clears `done`, `err`, `words`, the byte lane counter and the checksum.
- LEN0: accept byte -> `N[7:0]`, go to LEN1.
- LEN1: accept byte -> `N[15:8]`, then branch on `N`:
  - `N == 0` -> DONE.
  - `N > DEPTH - BASE` -> ERR; nothing is written.
  - Otherwise -> DATA.
- DATA: accepted byte `b` goes to lane `i` (0..3), so `word[8i+7:8i] = b` (first byte is LSB). After lane 3 -> WRITE.
- WRITE, exactly one cycle:
  - Drives `we=1`, `d_addr=BASE+words`, `di=word`.
  - Checksum ^= word; `words` increments.
  - Next state: DATA if `words+1 < N`, else VERIFY with readback index k=0.
- VERIFY: drives `d_addr=BASE+k` with `we=0`.
  - Each cycle, `do` is XORed into the readback sum and k increments.
  - After k = N-1, compare the readback sum with the checksum: equal -> DONE, else ERR.
- `s_ready` = 1 only in LEN0, LEN1 and DATA. Bytes presented in any other state are not consumed.
- `s_valid` low stalls indefinitely with no timeout; state and partial word are held.
- `start` in any other state is ignored; an in-flight load cannot be restarted except by reset.
- Address arithmetic: `BASE+words` and `BASE+k` are zero-extended to 32 bits and never wrap, which the length check guarantees.

## Timing
- Reset (async assert):
  - State -> IDLE.
  - Outputs: `s_ready=0`, `we=0`, `d_addr=0`, `di=0`, `cpu_hold=0`, `done=0`, `err=0`, `words=0`.
  - Reset mid-load abandons the load with no further write; memory contents already written are left as they are.
  - Reset deassertion is synchronised by the top level; after it, the first state change happens on a rising edge.
- Outputs `we`, `d_addr`, `di` are registered, so they have no combinational path from `s_*`.
- Per-word cost: 4 byte-accept cycles plus 1 WRITE cycle. With back-to-back bytes, a load of N words takes 2 + 5N cycles from LEN0 to VERIFY entry.
- VERIFY takes N cycles. `done`/`err` rise on the edge after the last VERIFY cycle.
- `cpu_hold` rises on the edge that leaves IDLE/DONE/ERR and falls on the edge that enters DONE/ERR.
- `we` is never high outside WRITE. `d_addr` holds its last value in DATA, DONE and ERR.

## Test plan
- Bytes 02 00 | 78 56 34 12 | EF BE AD DE, with `BASE=0`, back-to-back -> two writes:
  - `mem[0]=0x12345678`, `mem[1]=0xDEADBEEF`.
  - `words=2`, `done=1` after 2+10+2 cycles.
  - `cpu_hold` low afterwards.
- Same stream with `s_valid` dropped for 7 cycles mid-word -> identical memory contents. `s_ready` stays 1, and no write occurs until the 4th byte is accepted.
- Length 0x0201 (513) with `DEPTH=512` -> ERR right after LEN1. `we` is never asserted, `s_ready`=0, `err=1`.
- Length 0 -> DONE right after LEN1, `words=0`, no write.
- Force a verify failure by corrupting `do` on readback of word 1 in the bench (XOR with 0x1) -> ERR with `words=2`; `done` is never asserted.
- Reset asserted during WRITE of word 3 of 5 -> all outputs 0 immediately. A new `start` then loads 1 word to `BASE` correctly.
